// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch predictor: counter encoding,
// default geometry and the table-entry record.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam int DEF_ENTRIES = 16;
    localparam int DEF_TAG_W   = 8;
    // Widest tag possible with the smallest table (4 entries -> 2 index bits).
    localparam int MAX_TAG_W   = 28;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [31:0]          target;
        ctr_e                 ctr;
    } bp_entry_t;

    function automatic logic ctr_predicts_taken(ctr_e c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter step: increments on taken, decrements on
// not-taken, holds at SNT/ST, and passes the state through when not enabled.
module sat_counter2
    import bp_pkg::*;
(
    input  logic en,
    input  logic taken,
    input  ctr_e cur,
    output ctr_e next_state
);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = cur;
        if (en) begin
            if (taken && (cur != ST)) begin
                next_state = ctr_e'(cur + 2'd1);
            end else if (!taken && (cur != SNT)) begin
                next_state = ctr_e'(cur - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters, fetch
// lookup, execute-stage update, mispredict flush/redirect and statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] PC_F,
    output logic        pred_taken_F,
    output logic [31:0] pred_target_F,
    input  logic        br_valid_E,
    input  logic        stall_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] target_E,
    input  logic        take_branch,
    input  logic        pred_taken_E,
    input  logic [31:0] pred_target_E,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + TAG_W + 1;

    logic              valid_q  [ENTRIES];
    ctr_e              ctr_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];

    logic [IDX_W-1:0]  idx_f, idx_e;
    logic [TAG_W-1:0]  tag_f, tag_e;
    bp_entry_t         entry_f;
    logic              hit_f, hit_e;
    logic              upd;
    logic              ctr_en;
    ctr_e              ctr_next;
    ctr_e              ctr_wr;
    logic              unused_pc_bits;

    assign idx_f = PC_F[IDX_W+1:2];
    assign tag_f = PC_F[TAG_HI:TAG_LO];
    assign idx_e = PC_E[IDX_W+1:2];
    assign tag_e = PC_E[TAG_HI:TAG_LO];

    // Byte-offset and above-tag PC bits never address the table.
    assign unused_pc_bits = ^PC_F;

    // Fetch lookup reads registered state only, so a same-index update in
    // this cycle is not visible until the next one.
    always_comb begin
        entry_f.valid  = valid_q[idx_f];
        entry_f.tag    = MAX_TAG_W'(tag_q[idx_f]);
        entry_f.target = target_q[idx_f];
        entry_f.ctr    = ctr_q[idx_f];
    end

    assign hit_f         = entry_f.valid && (entry_f.tag == MAX_TAG_W'(tag_f));
    assign pred_taken_F  = hit_f && ctr_predicts_taken(entry_f.ctr);
    assign pred_target_F = hit_f ? entry_f.target : 32'd0;

    assign upd   = br_valid_E && !stall_E;
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    assign flush = upd && ((pred_taken_E != take_branch) ||
                           (take_branch && (pred_target_E != target_E)));
    assign redirect_pc = take_branch ? target_E : (PC_E + 32'd4);

    assign ctr_en = hit_e;

    sat_counter2 u_ctr (
        .en         (ctr_en),
        .taken      (take_branch),
        .cur        (ctr_q[idx_e]),
        .next_state (ctr_next)
    );

    // A taken branch that misses allocates a fresh entry in weakly-taken.
    assign ctr_wr = (take_branch && !hit_e) ? WT : ctr_next;

    // NOTE: only valid bits and counters are reset; tag/target storage is plain RAM,
    // and an entry with valid=0 hides whatever it holds.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WNT;
            end
            br_count      <= 32'd0;
            mispred_count <= 32'd0;
        end else begin
            if (upd && (take_branch || hit_e)) begin
                ctr_q[idx_e] <= ctr_wr;
                if (take_branch) begin
                    valid_q[idx_e] <= 1'b1;
                end
            end
            if (upd && (br_count != 32'hFFFF_FFFF)) begin
                br_count <= br_count + 32'd1;
            end
            if (flush && (mispred_count != 32'hFFFF_FFFF)) begin
                mispred_count <= mispred_count + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (upd && take_branch) begin
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= target_E;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural table model.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = $clog2(ENTRIES);

    logic        CLK;
    logic        RST_N;
    logic [31:0] PC_F;
    logic        pred_taken_F;
    logic [31:0] pred_target_F;
    logic        br_valid_E;
    logic        stall_E;
    logic [31:0] PC_E;
    logic [31:0] target_E;
    logic        take_branch;
    logic        pred_taken_E;
    logic [31:0] pred_target_E;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .PC_F          (PC_F),
        .pred_taken_F  (pred_taken_F),
        .pred_target_F (pred_target_F),
        .br_valid_E    (br_valid_E),
        .stall_E       (stall_E),
        .PC_E          (PC_E),
        .target_E      (target_E),
        .take_branch   (take_branch),
        .pred_taken_E  (pred_taken_E),
        .pred_target_E (pred_target_E),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one record per table slot, counters as plain 0..3 integers.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    longint      m_br;
    longint      m_mis;
    bit          model_on = 1'b0;

    function automatic int unsigned idx_of(logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(logic [31:0] pc);
        return (pc >> (2 + IDX_W)) % (1 << TAG_W);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptarget(logic [31:0] pc);
        return m_hit(pc) ? m_target[idx_of(pc)] : 32'd0;
    endfunction

    function automatic bit m_flush();
        if (!(br_valid_E && !stall_E)) return 1'b0;
        if (pred_taken_E != take_branch) return 1'b1;
        return take_branch && (pred_target_E != target_E);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    always @(negedge RST_N) model_reset();

    always @(posedge CLK) begin
        if (RST_N && br_valid_E && !stall_E) begin
            int unsigned i;
            bit hit;
            i   = idx_of(PC_E);
            hit = m_hit(PC_E);
            if (m_flush() && m_mis < 64'hFFFF_FFFF) m_mis++;
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (take_branch) begin
                m_ctr[i]    = hit ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : 2;
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(PC_E);
                m_target[i] = target_E;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (model_on) begin
            check("m_pred_taken_F",  {31'd0, pred_taken_F}, {31'd0, m_pred(PC_F)});
            check("m_pred_target_F", pred_target_F, m_ptarget(PC_F));
            check("m_flush",         {31'd0, flush}, {31'd0, m_flush()});
            check("m_redirect_pc",   redirect_pc, take_branch ? target_E : PC_E + 32'd4);
            check("m_br_count",      br_count, m_br[31:0]);
            check("m_mispred_count", mispred_count, m_mis[31:0]);
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                              input logic ptaken, input logic [31:0] ptgt);
        br_valid_E    = 1'b1;
        stall_E       = 1'b0;
        PC_E          = pc;
        take_branch   = taken;
        target_E      = tgt;
        pred_taken_E  = ptaken;
        pred_target_E = ptgt;
    endtask

    initial begin
        RST_N = 1'b0;
        PC_F = 32'd0; br_valid_E = 1'b0; stall_E = 1'b0; PC_E = 32'd0;
        target_E = 32'd0; take_branch = 1'b0; pred_taken_E = 1'b0; pred_target_E = 32'd0;
        model_reset();
        repeat (2) next_cycle();
        RST_N = 1'b1;
        model_on = 1'b1;

        // Reset state
        PC_F = 32'h100;
        @(negedge CLK);
        check("rst_pred_taken",  {31'd0, pred_taken_F}, 32'd0);
        check("rst_pred_target", pred_target_F, 32'd0);
        check("rst_br_count",    br_count, 32'd0);
        check("rst_flush",       {31'd0, flush}, 32'd0);

        // First taken branch allocates in WT
        next_cycle();
        set_branch(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        @(negedge CLK);
        check("alloc_flush",    {31'd0, flush}, 32'd1);
        check("alloc_redirect", redirect_pc, 32'h80);
        next_cycle();
        br_valid_E = 1'b0;
        @(negedge CLK);
        check("alloc_pred_taken",  {31'd0, pred_taken_F}, 32'd1);
        check("alloc_pred_target", pred_target_F, 32'h80);
        check("alloc_br_count",    br_count, 32'd1);

        // Saturate to ST, then one not-taken drops only to WT
        next_cycle();
        set_branch(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        repeat (4) next_cycle();
        set_branch(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        @(negedge CLK);
        check("nt_flush",    {31'd0, flush}, 32'd1);
        check("nt_redirect", redirect_pc, 32'h104);
        next_cycle();
        br_valid_E = 1'b0;
        @(negedge CLK);
        check("st_to_wt_pred", {31'd0, pred_taken_F}, 32'd1);
        check("nt_br_count",   br_count, 32'd6);
        check("nt_mis_count",  mispred_count, 32'd2);

        // Alias at the same index with a different tag replaces the entry
        next_cycle();
        set_branch(32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
        next_cycle();
        br_valid_E = 1'b0;
        @(negedge CLK);
        check("alias_old_miss",   {31'd0, pred_taken_F}, 32'd0);
        check("alias_old_target", pred_target_F, 32'd0);
        next_cycle();
        PC_F = 32'h140;
        @(negedge CLK);
        check("alias_new_target", pred_target_F, 32'h200);

        // Stalled branch changes nothing and never flushes
        next_cycle();
        set_branch(32'h140, 1'b0, 32'h200, 1'b1, 32'h200);
        stall_E = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("stall_flush",    {31'd0, flush}, 32'd0);
            check("stall_br_count", br_count, 32'd7);
            next_cycle();
        end
        stall_E = 1'b0;
        @(negedge CLK);
        check("same_idx_old_pred", {31'd0, pred_taken_F}, 32'd1);
        next_cycle();
        br_valid_E = 1'b0;
        @(negedge CLK);
        check("same_idx_new_pred", {31'd0, pred_taken_F}, 32'd0);
        check("same_idx_target",   pred_target_F, 32'h200);
        check("same_idx_mis",      mispred_count, 32'd4);

        // Asynchronous reset in the middle of an update cycle
        next_cycle();
        set_branch(32'h100, 1'b1, 32'h300, 1'b1, 32'h80);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("arst_pred_taken", {31'd0, pred_taken_F}, 32'd0);
        check("arst_target",     pred_target_F, 32'd0);
        check("arst_br_count",   br_count, 32'd0);
        check("arst_mis_count",  mispred_count, 32'd0);
        next_cycle();
        PC_F = 32'h100;
        @(negedge CLK);
        check("arst_hold_pred", {31'd0, pred_taken_F}, 32'd0);
        next_cycle();
        br_valid_E = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);
        check("arst_after_target", pred_target_F, 32'd0);
        check("arst_after_br",     br_count, 32'd0);

        // Randomized traffic over a small PC pool to force hits and aliases
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pcs [2];
            next_cycle();
            for (int k = 0; k < 2; k++) begin
                pcs[k] = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
                if ($urandom_range(0, 15) == 0) pcs[k] = $urandom();
            end
            PC_F        = pcs[0];
            PC_E        = pcs[1];
            br_valid_E  = ($urandom_range(0, 3) != 0);
            stall_E     = ($urandom_range(0, 4) == 0);
            take_branch = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       target_E = 32'h80;
                1:       target_E = 32'h200;
                2:       target_E = 32'hFFFF_FFFC;
                default: target_E = $urandom();
            endcase
            if ($urandom_range(0, 1) != 0) begin
                pred_taken_E  = m_pred(PC_E);
                pred_target_E = m_ptarget(PC_E);
            end else begin
                pred_taken_E  = $urandom_range(0, 1);
                pred_target_E = ($urandom_range(0, 1) != 0) ? target_E : $urandom();
            end
        end

        next_cycle();
        br_valid_E = 1'b0;
        @(negedge CLK);
        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
